// File: rtl/cnt_cmd_seq.sv
// Purpose : command sequencer that turns queued HOLD/LOAD/UP/DOWN commands into counter control pins.
// Latency : a command accepted into an empty, idle sequencer drives its first outputs one cycle later.
// Backpr. : cmd_ready_o drops when the command FIFO is full; it is forced high during abort (command is dropped).
//
// Ports:
//   clk_i, rst_ni        clock (posedge) and asynchronous active-low reset
//   cmd_valid_i/ready_o  command handshake; cmd_op_i (00 HOLD, 01 LOAD, 10 UP, 11 DOWN), cmd_data_i
//   abort_i              flushes the FIFO and the active command at the next edge
//   en_o, load_o,        registered counter controls; in_data_o is the load value
//   updown_o, in_data_o
//   busy_o               registered: a command is executing or the FIFO is non-empty
//   cmd_done_o           registered one-cycle pulse on the last drive cycle of each command
module cnt_cmd_seq #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic              abort_i,
  output logic              en_o,
  output logic              load_o,
  output logic              updown_o,
  output logic [DATA_W-1:0] in_data_o,
  output logic              busy_o,
  output logic              cmd_done_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_HOLD} state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // ---------------------------------------------------------------- FIFO
  cmd_t        fifo_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        empty, full, push, pop;
  cmd_t        head;

  // Extra pointer MSB: equal pointers mean empty, MSB-only difference means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // During abort the offered command is swallowed, so ready may stay high.
  assign cmd_ready_o = !full || abort_i;
  assign push        = cmd_valid_i && !full && !abort_i;
  assign head        = fifo_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= {cmd_op_i, cmd_data_i};
    end
  end

  // ---------------------------------------------------------------- FSM
  state_e            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;       // drive cycles remaining after the current one
  logic              en_q, en_d, load_q, load_d, updown_q, updown_d;
  logic              done_q, done_d, busy_q, busy_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              last;               // current cycle is the final one of its command

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    load_d    = 1'b0;
    updown_d  = updown_q;
    in_data_d = in_data_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    last      = 1'b0;

    case (state_q)
      ST_RUN, ST_HOLD: begin
        if (cnt_q == '0) begin
          last = 1'b1;
        end else begin
          cnt_d  = cnt_q - ONE;
          done_d = (cnt_q == ONE);
        end
      end
      default: last = 1'b1;  // IDLE and single-cycle LOAD
    endcase

    // Retire and, if possible, launch the next command at the same edge.
    if (last) begin
      en_d    = 1'b0;
      state_d = ST_IDLE;
      cnt_d   = '0;
      if (!empty) begin
        pop = 1'b1;
        if (head.op == OP_LOAD) begin
          state_d   = ST_LOAD;
          load_d    = 1'b1;
          in_data_d = head.data;
          done_d    = 1'b1;
        end else if (head.data == '0) begin
          // Zero-length command: one idle-looking cycle that only pulses done.
          state_d = ST_HOLD;
          done_d  = 1'b1;
        end else if (head.op == OP_HOLD) begin
          state_d = ST_HOLD;
          cnt_d   = head.data - ONE;
          done_d  = (head.data == ONE);
        end else begin
          state_d  = ST_RUN;
          en_d     = 1'b1;
          updown_d = (head.op == OP_UP);
          cnt_d    = head.data - ONE;
          done_d   = (head.data == ONE);
        end
      end
    end

    if (abort_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      en_d    = 1'b0;
      load_d  = 1'b0;
      done_d  = 1'b0;
      pop     = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    if (abort_i) begin
      rd_ptr_d = wr_ptr_q;  // push is blocked during abort, so this empties the FIFO
    end
    // Registered busy reflects the state and occupancy that follow this edge.
    busy_d = (state_d != ST_IDLE) || (wr_ptr_d != rd_ptr_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      load_q    <= 1'b0;
      updown_q  <= 1'b0;
      in_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      load_q    <= load_d;
      updown_q  <= updown_d;
      in_data_q <= in_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign en_o       = en_q;
  assign load_o     = load_q;
  assign updown_o   = updown_q;
  assign in_data_o  = in_data_q;
  assign cmd_done_o = done_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/cnt_cmd_seq.md
Name: cnt_cmd_seq

Overview:
Upstream command sequencer for the 8-bit up/down counter. It accepts high-level commands over a valid/ready handshake and buffers them in a small FIFO. It executes the commands in order and produces the cycle-level counter control pins: en, load, updown and in_data. The counter consumes these outputs directly; its clocking block samples them at posedge clk.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
DATA_W, 8, width of in_data and the command payload.

Ports:
clk  input  1  clock; all logic is on posedge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  FIFO can accept a command (= !full).
cmd_op  input  2  00 HOLD, 01 LOAD, 10 UP, 11 DOWN.
cmd_data  input  DATA_W  LOAD value, or cycle count N for HOLD/UP/DOWN.
abort  input  1  synchronous flush of the FIFO and the active command.
en  output  1  counter enable.
load  output  1  counter parallel load.
updown  output  1  1 = count up, 0 = count down.
in_data  output  DATA_W  counter load value.
busy  output  1  a command is executing, or the FIFO is non-empty.
cmd_done  output  1  one-cycle pulse on the last drive cycle of each command.

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE, and en=load=updown=cmd_done=busy=0, in_data=0. cmd_ready=1 after reset.
- All outputs are registered, except cmd_ready, which is combinational from FIFO occupancy.
- Handshake: a command is written when cmd_valid && cmd_ready at a posedge. cmd_op and cmd_data must stay stable while cmd_valid=1 and cmd_ready=0.
- Full FIFO: cmd_ready=0. A simultaneous pop and push in the same cycle is allowed only when the FIFO is not full.
- Latency: a command accepted at edge E0 into an empty, idle sequencer drives its first outputs from edge E1 (1 cycle).
- FSM states: IDLE, LOAD, RUN, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head and go to the state given by cmd_op. Otherwise outputs stay 0.
  - LOAD: one cycle with load=1, en=0, in_data=cmd_data, cmd_done=1.
  - RUN (UP/DOWN): en=1, updown=(op==UP), load=0 for exactly N cycles. An internal DATA_W-bit down-counter tracks the remaining cycles. cmd_done=1 on the Nth cycle.
  - HOLD: en=0, load=0 for exactly N cycles. cmd_done=1 on the Nth cycle.
  - in_data holds the last LOAD value outside LOAD cycles. updown holds its last value during HOLD and IDLE.
- N=0 for HOLD/UP/DOWN: no drive cycles. The command retires in a single cycle with en=load=0 and cmd_done=1.
- Back-to-back: on a command's last cycle, if the FIFO is non-empty, the next command is popped at the same edge. There is no idle bubble between commands.
- If the FIFO is empty at the last cycle, the FSM returns to IDLE and en/load deassert at the next edge.
- abort: at the next edge the FIFO empties, the FSM goes to IDLE, and en=load=cmd_done=0.
  - A command presented in the same cycle as abort is dropped.
  - cmd_ready stays 1 during abort.
- busy = (state != IDLE) || !empty, registered.
- FIFO pointers wrap modulo FIFO_DEPTH and use an extra bit to distinguish full from empty.
- Reset mid-command: all outputs return to their reset values immediately, and all queued commands are lost.

Test Plan:
- LOAD 0x5A, then UP N=3 -> load=1, in_data=0x5A for 1 cycle, then en=1, updown=1 for exactly 3 cycles. The counter goes 0x5A→0x5D. cmd_done pulses twice.
- DOWN N=2 after LOAD 0x01 -> en=1, updown=0 for 2 cycles. The counter wraps 0x01→0x00→0xFF.
- Push 5 commands with FIFO_DEPTH=4 and the sequencer stalled by a HOLD N=10 -> cmd_ready=0 after 4 are queued (the HOLD is already popped). All commands execute in order with no bubbles.
- UP N=0 between two LOADs -> a single cycle with en=0 and a cmd_done pulse. The LOADs are separated by exactly 1 cycle.
- abort asserted during UP N=100 at drive cycle 20 with 2 queued commands -> en=0 from the next edge, busy=0, and the queued commands are never driven.
- rst_n asserted asynchronously mid-RUN -> en/load/updown/in_data go to 0 immediately without waiting for clk. cmd_ready=1 after release.
